// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with 7-bit address match, write delivery and read fetch.
// SCL/SDA are oversampled on clk100mhz. SDA is open-drain (0 or Z) and there is
// no clock stretching.
// Optional: define I2C_SLAVE_GEN_CALL_EN to also accept the general-call write
// address 8'h00.
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk100mhz,
  input  logic       res,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       nack_seen
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       nack_q, nack_d;

  logic [7:0] rx_byte;
  logic       bit_last;
  logic       addr_hit;
  logic       gc_hit;

  // Open-drain SDA: pull low or release.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // Input synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk100mhz) begin
    if (res) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

  assign rx_byte  = {shift_q[6:0], sda_s};
  assign bit_last = (bit_cnt_q == 4'd7);
  assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);
`ifdef I2C_SLAVE_GEN_CALL_EN
  assign gc_hit   = (rx_byte == 8'h00);
`else
  assign gc_hit   = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk100mhz) begin
    if (res) begin
      state_q    <= S_IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 4'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
    end
  end

  // Next-state logic; bus START/STOP override bit-level processing.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    nack_d     = 1'b0;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_last) begin
              bit_cnt_d = 4'd0;
              rw_d      = rx_byte[0];
              state_d   = (addr_hit || gc_hit) ? S_ADDR_ACK : S_IGNORE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // sda_oe_q distinguishes the ACK-drive fall from the ACK-release fall.
        S_ADDR_ACK: begin
          if (scl_rise && sda_oe_q && rw_q) tx_req_d = 1'b1;
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else if (rw_q) begin
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              bit_cnt_d = 4'd0;
              state_d   = S_RD_DATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_last) begin
              bit_cnt_d  = 4'd0;
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = S_WR_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WR_DATA;
            end
          end
        end
        // Rotate so the next bit to present is always in shift_q[7].
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_last) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_ACK;
            end else begin
              shift_d   = {shift_q[6:0], shift_q[7]};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              state_d = S_IGNORE;
            end
          end else if (scl_fall) begin
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            bit_cnt_d = 4'd0;
            state_d   = S_RD_DATA;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master, fabric responder and scoreboard for i2c_slave.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 12;  // clk cycles per SCL half-period

`ifdef I2C_SLAVE_GEN_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, nack_seen;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave dut (
    .clk100mhz (clk),
    .res       (res),
    .scl       (scl),
    .sda       (sda),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0, txreq_cnt = 0, nack_cnt = 0, dut_low_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_src[$];
  logic [7:0] wbytes[$];
  logic [7:0] rbytes[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference rule: which address bytes the target acknowledges.
  function automatic bit addr_acks(input logic [7:0] a);
    return (a[7:1] == 7'h50) || (GC_EN && a == 8'h00);
  endfunction

  // Monitor: scoreboard for written bytes, fabric responder, event counters.
  always @(negedge clk) begin
    if (!res) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() == 0) chk("rx_valid_unexpected", 1, 0);
        else chk("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
      end
      if (tx_req) begin
        txreq_cnt++;
        if (tx_src.size() == 0) chk("tx_req_unexpected", 1, 0);
        else tx_data = tx_src.pop_front();
      end
      if (nack_seen) nack_cnt++;
      if (sda === 1'b0 && !m_low) dut_low_cnt++;
    end
  end

  task automatic waitq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; waitq(Q);
    scl = 1'b1;   waitq(Q);
    m_low = 1'b1; waitq(Q);
    scl = 1'b0;   waitq(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; waitq(Q);
    scl = 1'b1;   waitq(Q);
    m_low = 1'b0; waitq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_low, output logic busy_s);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; waitq(Q);
      scl = 1'b1;    waitq(Q);
      scl = 1'b0;    waitq(2);
    end
    m_low = 1'b0; waitq(Q);
    scl = 1'b1;   waitq(Q / 2);
    ack_low = (sda === 1'b0);
    busy_s  = busy;
    waitq(Q / 2);
    scl = 1'b0;   waitq(Q);
  endtask

  task automatic read_byte(input bit ack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      waitq(Q);
      scl = 1'b1; waitq(Q / 2);
      b[i] = (sda === 1'b0) ? 1'b0 : 1'b1;
      waitq(Q / 2);
      scl = 1'b0; waitq(2);
    end
    m_low = ack; waitq(Q);
    scl = 1'b1;  waitq(Q);
    scl = 1'b0;  waitq(2);
    m_low = 1'b0; waitq(Q);
  endtask

  // Full write transaction of wbytes to address byte addr, then STOP.
  task automatic do_write(input logic [7:0] addr);
    logic a, bz;
    bit   exp;
    int   rx0, low0;
    exp  = addr_acks(addr) && !addr[0];
    rx0  = rx_cnt;
    low0 = dut_low_cnt;
    i2c_start();
    write_byte(addr, a, bz);
    chk("wr_addr_ack", a, exp);
    chk("wr_busy_at_ack", bz, exp);
    foreach (wbytes[i]) begin
      if (exp) exp_rx.push_back(wbytes[i]);
      write_byte(wbytes[i], a, bz);
      chk("wr_data_ack", a, exp);
    end
    i2c_stop(); waitq(Q);
    chk("wr_rx_count", rx_cnt - rx0, exp ? wbytes.size() : 0);
    chk("wr_busy_after_stop", busy, 0);
    if (!exp) chk("wr_sda_never_driven", dut_low_cnt - low0, 0);
  endtask

  // Read of rbytes from 0xA1: ACK all but the last byte, NACK the last.
  task automatic do_read();
    logic a, bz;
    logic [7:0] b;
    int t0, n0, n;
    t0 = txreq_cnt;
    n0 = nack_cnt;
    n  = rbytes.size();
    foreach (rbytes[i]) tx_src.push_back(rbytes[i]);
    i2c_start();
    write_byte(8'hA1, a, bz);
    chk("rd_addr_ack", a, 1);
    chk("rd_busy_at_ack", bz, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, b);
      chk("rd_byte", int'(b), int'(rbytes[i]));
    end
    i2c_stop(); waitq(Q);
    chk("rd_tx_req_count", txreq_cnt - t0, n);
    chk("rd_nack_count", nack_cnt - n0, 1);
    chk("rd_busy_after_stop", busy, 0);
  endtask

  initial begin
    logic a, bz;
    logic [7:0] b;
    logic [7:0] addr;
    int nb;

    waitq(5);
    res = 1'b0;
    waitq(4);
    chk("rst_sda", sda === 1'b1, 1);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nack_seen", nack_seen, 0);

    // Basic write of two bytes.
    wbytes = '{8'h3C, 8'h81};
    do_write(8'hA0);
    chk("wr_last_rx_data", int'(rx_data), 8'h81);

    // Address mismatch.
    wbytes = '{8'h55};
    do_write(8'hA2);

    // Read two bytes.
    rbytes = '{8'hA5, 8'h0F};
    do_read();

    // Write 0x10, repeated START, read 0x77.
    i2c_start();
    exp_rx.push_back(8'h10);
    write_byte(8'hA0, a, bz); chk("sr_addr1_ack", a, 1);
    write_byte(8'h10, a, bz); chk("sr_data_ack", a, 1);
    tx_src.push_back(8'h77);
    i2c_start();
    write_byte(8'hA1, a, bz); chk("sr_addr2_ack", a, 1);
    read_byte(1'b0, b);       chk("sr_rd_byte", int'(b), 8'h77);
    i2c_stop(); waitq(Q);
    chk("sr_rx_data", int'(rx_data), 8'h10);

    // Reset while the target drives a 0 bit of 0x00.
    tx_src.push_back(8'h00);
    i2c_start();
    write_byte(8'hA1, a, bz); chk("rr_addr_ack", a, 1);
    chk("rr_bit_driven_low", sda === 1'b0, 1);
    res = 1'b1;
    @(posedge clk); #1;
    chk("rr_sda_released", sda === 1'b1, 1);
    chk("rr_busy", busy, 0);
    chk("rr_rx_data", int'(rx_data), 0);
    chk("rr_tx_req", tx_req, 0);
    @(negedge clk);
    res = 1'b0;
    scl = 1'b1; waitq(Q);
    wbytes = '{8'h5A};
    do_write(8'hA0);

    // General call write.
    wbytes = '{8'h06};
    do_write(8'h00);
    if (GC_EN) chk("gc_rx_data", int'(rx_data), 8'h06);

    // Randomized writes and reads.
    for (int it = 0; it < 8; it++) begin
      addr = ($urandom_range(0, 1) == 0) ? 8'hA0 : 8'($urandom_range(0, 255)) & 8'hFE;
      nb = $urandom_range(1, 3);
      wbytes = {};
      for (int k = 0; k < nb; k++) wbytes.push_back(8'($urandom_range(0, 255)));
      do_write(addr);
      nb = $urandom_range(1, 3);
      rbytes = {};
      for (int k = 0; k < nb; k++) rbytes.push_back(8'($urandom_range(0, 255)));
      do_read();
    end

    chk("exp_rx_drained", exp_rx.size(), 0);
    chk("tx_src_drained", tx_src.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
